// File: rtl/out_buf.sv
// Ping-pong output buffer: the core fills one bank while the other drains through a
// 4-entry skid FIFO onto a valid/ready stream. Optional macro OUT_BUF_RELU_EN clamps negative words to zero.
module out_buf #(
  parameter int DW    = 16,
  parameter int AW    = 12,
  parameter int DEPTH = 4096
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  input  logic          outp,
  input  logic          wr_v,
  input  logic [AW-1:0] wr_a,
  input  logic [DW-1:0] wr_d,
  input  logic          rd_v,
  input  logic [AW-1:0] rd_a,
  input  logic [AW-1:0] ds,
  output logic          rd_ready,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  input  logic          m_ready
);

  logic          wr_bank;
  logic [DW-1:0] bank_rd [2];

  logic          pend_reg;
  logic          bank_sel_reg;
  logic          last_tag_reg;

  logic [DW:0]   fifo_mem [4];
  logic [1:0]    wptr_reg;
  logic [1:0]    rptr_reg;
  logic [2:0]    count_reg;

  logic [DW-1:0] raw_word;
  logic [DW-1:0] push_word;
  logic [DW:0]   head;
  logic          push;
  logic          pop;
  logic [3:0]    occupancy;

  assign wr_bank = ~outp;

  // Each bank is a plain array with a registered read so it maps onto block RAM.
  // The core only ever writes bank ~outp, so a bank is never read and written in one cycle.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      logic [DW-1:0] mem [DEPTH];
      logic [DW-1:0] rd_q_reg;

      always_ff @(posedge clk) begin
        if (wr_v && (wr_bank == 1'(gi)))
          mem[wr_a] <= wr_d;
        if (rd_v)
          rd_q_reg <= mem[rd_a];
      end

      assign bank_rd[gi] = rd_q_reg;
    end
  endgenerate

  // Bank and last tag are captured at issue so an outp toggle cannot corrupt the return.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_reg     <= 1'b0;
      bank_sel_reg <= 1'b0;
      last_tag_reg <= 1'b0;
    end else if (!run) begin
      pend_reg     <= 1'b0;
    end else begin
      pend_reg <= rd_v;
      if (rd_v) begin
        bank_sel_reg <= outp;
        last_tag_reg <= (rd_a == ds);
      end
    end
  end

  assign raw_word = bank_sel_reg ? bank_rd[1] : bank_rd[0];

`ifdef OUT_BUF_RELU_EN
  assign push_word = raw_word[DW-1] ? '0 : raw_word;
`else
  assign push_word = raw_word;
`endif

  assign head = fifo_mem[rptr_reg];
  assign push = pend_reg;
  assign pop  = m_valid & m_ready;

  always_ff @(posedge clk) begin
    if (run && push)
      fifo_mem[wptr_reg] <= {last_tag_reg, push_word};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_reg  <= 2'd0;
      rptr_reg  <= 2'd0;
      count_reg <= 3'd0;
    end else if (!run) begin
      wptr_reg  <= 2'd0;
      rptr_reg  <= 2'd0;
      count_reg <= 3'd0;
    end else begin
      if (push)
        wptr_reg <= wptr_reg + 2'd1;
      if (pop)
        rptr_reg <= rptr_reg + 2'd1;
      if (push && !pop)
        count_reg <= count_reg + 3'd1;
      else if (!push && pop)
        count_reg <= count_reg - 3'd1;
    end
  end

  // Credit counts the in-flight read so the FIFO can absorb it without looking at m_ready.
  assign occupancy = {1'b0, count_reg} + {3'b000, pend_reg};
  assign rd_ready  = (occupancy < 4'd4);

  assign m_valid = (count_reg != 3'd0);
  assign m_data  = m_valid ? head[DW-1:0] : '0;
  assign m_last  = m_valid ? head[DW] : 1'b0;

endmodule

// File: tb/tb_out_buf.sv
// Directed bench for out_buf: a scoreboard queue of {last, data} is filled at read issue
// and checked against every accepted stream beat.
module tb_out_buf;
  localparam int DW = 16;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run = 1'b0;
  logic          outp = 1'b0;
  logic          wr_v = 1'b0;
  logic [AW-1:0] wr_a = '0;
  logic [DW-1:0] wr_d = '0;
  logic          rd_v = 1'b0;
  logic [AW-1:0] rd_a = '0;
  logic [AW-1:0] ds = '0;
  logic          rd_ready;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          m_ready = 1'b0;

  out_buf #(.DW(DW), .AW(AW), .DEPTH(4096)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .outp     (outp),
    .wr_v     (wr_v),
    .wr_a     (wr_a),
    .wr_d     (wr_d),
    .rd_v     (rd_v),
    .rd_a     (rd_a),
    .ds       (ds),
    .rd_ready (rd_ready),
    .m_valid  (m_valid),
    .m_data   (m_data),
    .m_last   (m_last),
    .m_ready  (m_ready)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] model0 [256];
  logic [DW-1:0] model1 [256];
  logic [DW:0]   sb [$];
  int            n_vec = 0;
  int            n_err = 0;
  int            n_iss;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] expect_word(input logic [DW-1:0] d);
`ifdef OUT_BUF_RELU_EN
    return d[DW-1] ? '0 : d;
`else
    return d;
`endif
  endfunction

  // One clock cycle: score a handshake, record issue/write in the model, advance past the edge.
  task automatic tick();
    logic [DW:0]   e;
    logic [DW-1:0] d;
    if (m_valid && m_ready) begin
      check("beat_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("beat_data", 32'(m_data), 32'(e[DW-1:0]));
        check("beat_last", 32'(m_last), 32'(e[DW]));
      end
    end
    if (rd_v && run && rst_n) begin
      d = outp ? model1[rd_a[7:0]] : model0[rd_a[7:0]];
      sb.push_back({(rd_a == ds), expect_word(d)});
    end
    if (wr_v) begin
      if (outp) model0[wr_a[7:0]] = wr_d;
      else      model1[wr_a[7:0]] = wr_d;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_v = 1'b1;
    wr_a = a;
    wr_d = d;
    tick();
    wr_v = 1'b0;
  endtask

  task automatic read1(input logic [AW-1:0] a);
    rd_v = 1'b1;
    rd_a = a;
    tick();
    rd_v = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++)
      tick();
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #2;
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_rd_ready", 32'(rd_ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run   = 1'b1;
    tick();

    // Fill bank 0 with 1..8, bank 1 addr 3, bank 0 addr 5 gets 0x1234 later
    outp = 1'b1;
    for (int i = 0; i < 8; i++)
      write(AW'(i), DW'(i + 1));
    outp = 1'b0;
    write(AW'(3), 16'h0A03);

    // Frame 1: full-rate drain, first beat two cycles after first issue
    ds = AW'(7);
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("f1_rd_ready", 32'(rd_ready), 32'd1);
      rd_v = 1'b1;
      rd_a = AW'(i);
      tick();
      check("f1_valid", 32'(m_valid), 32'(i >= 1));
    end
    rd_v = 1'b0;
    check("f1_tail_valid0", 32'(m_valid), 32'd1);
    tick();
    check("f1_tail_valid1", 32'(m_valid), 32'd1);
    tick();
    check("f1_end_valid", 32'(m_valid), 32'd0);
    check("f1_sb_empty", 32'(sb.size()), 32'd0);

    // Frame 2: back-pressure stalls after exactly four credits
    m_ready = 1'b0;
    n_iss = 0;
    for (int c = 0; c < 10; c++) begin
      rd_v = rd_ready && (n_iss < 8);
      if (rd_v) begin
        rd_a = AW'(n_iss);
        n_iss++;
      end
      tick();
    end
    rd_v = 1'b0;
    check("f2_accepted", 32'(n_iss), 32'd4);
    check("f2_full_rd_ready", 32'(rd_ready), 32'd0);
    check("f2_full_valid", 32'(m_valid), 32'd1);
    m_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (n_iss == 8 && sb.size() == 0) break;
      rd_v = rd_ready && (n_iss < 8);
      if (rd_v) begin
        rd_a = AW'(n_iss);
        n_iss++;
      end
      tick();
    end
    rd_v = 1'b0;
    check("f2_issued", 32'(n_iss), 32'd8);
    check("f2_sb_empty", 32'(sb.size()), 32'd0);

    // Frame 3: outp toggles right after issue; word comes from bank 0
    outp = 1'b0;
    ds = AW'(3);
    rd_v = 1'b1;
    rd_a = AW'(3);
    tick();
    rd_v = 1'b0;
    outp = 1'b1;
    tick();
    drain(10);

    // Frame 4: concurrent write to bank 1 while draining bank 0 at the same address
    outp = 1'b1;
    write(AW'(5), 16'h1234);
    outp = 1'b0;
    ds = AW'(5);
    rd_v = 1'b1;
    rd_a = AW'(5);
    wr_v = 1'b1;
    wr_a = AW'(5);
    wr_d = 16'hBEEF;
    tick();
    rd_v = 1'b0;
    wr_v = 1'b0;
    drain(10);
    outp = 1'b1;
    read1(AW'(5));
    drain(10);

    // Flush with three words queued
    outp = 1'b0;
    ds = AW'(7);
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rd_v = 1'b1;
      rd_a = AW'(i);
      tick();
    end
    rd_v = 1'b0;
    tick();
    check("flush_pre_valid", 32'(m_valid), 32'd1);
    run = 1'b0;
    tick();
    check("flush_valid", 32'(m_valid), 32'd0);
    check("flush_rd_ready", 32'(rd_ready), 32'd1);
    sb.delete();
    run = 1'b1;
    tick();

    // Asynchronous reset in the middle of a burst
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rd_v = 1'b1;
      rd_a = AW'(i);
      tick();
    end
    check("burst_valid", 32'(m_valid), 32'd1);
    rst_n = 1'b0;
    rd_v  = 1'b0;
    #1;
    check("arst_valid", 32'(m_valid), 32'd0);
    check("arst_rd_ready", 32'(rd_ready), 32'd1);
    check("arst_last", 32'(m_last), 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // Signed words: clamped only when the ReLU option is built in
    outp = 1'b1;
    write(AW'(8), 16'h8005);
    write(AW'(9), 16'h7FFF);
    outp = 1'b0;
    ds = AW'(9);
    m_ready = 1'b1;
    rd_v = 1'b1;
    rd_a = AW'(8);
    tick();
    rd_a = AW'(9);
    tick();
    rd_v = 1'b0;
    drain(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
